// File: rtl/instr_decode_stage.sv
// Registered instruction decode stage: decodes six instruction groups into a valid/ready FIFO,
// holds the output after stall-causing records, supports flush and counts invalid instructions.
`timescale 1ns/1ps
module instr_decode_stage #(
    parameter int unsigned IMM_WIDTH     = 16,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned STALL_CYCLES  = 2,
    parameter logic [3:0]  BRANCH_MAX_OP = 4'd9,
    parameter logic [3:0]  JUMP_MAX_OP   = 4'd9,
    parameter logic [3:0]  CALL_MAX_OP   = 4'd9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_group,
    output logic [3:0]           out_ra,
    output logic [3:0]           out_rb,
    output logic [3:0]           out_rc,
    output logic [3:0]           out_opcode,
    output logic [IMM_WIDTH-1:0] out_imm,
    output logic [1:0]           out_ldst_type,
    output logic                 out_causes_stall,
    output logic                 out_bad,
    output logic [15:0]          bad_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES + 1) : 1;
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [3:0]           group;
        logic [3:0]           ra;
        logic [3:0]           rb;
        logic [3:0]           rc;
        logic [3:0]           opcode;
        logic [IMM_WIDTH-1:0] imm;
        logic [1:0]           ldst_type;
        logic                 causes_stall;
        logic                 bad;
    } rec_t;

    typedef enum logic {StRun, StHold} state_e;

    rec_t          dec;
    rec_t          rd_rec;
    rec_t          mem_q [DEPTH];
    rec_t          mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_e        state_q, state_d;
    logic [15:0]   bad_count_q, bad_count_d;
    logic          full, empty, push, pop;

    always_comb begin
        dec       = '0;
        dec.ra    = in_instr[27:24];
        dec.rb    = in_instr[23:20];
        dec.group = in_instr[31:28];
        unique case (in_instr[31:28])
            4'd0, 4'd3, 4'd4: begin
                dec.rc     = in_instr[19:16];
                dec.opcode = in_instr[3:0];
                if (in_instr[31:28] == 4'd3) dec.causes_stall = (in_instr[3:0] <= JUMP_MAX_OP);
                if (in_instr[31:28] == 4'd4) dec.causes_stall = (in_instr[3:0] <= CALL_MAX_OP);
            end
            4'd1, 4'd2: begin
                dec.opcode = in_instr[19:16];
                dec.imm    = IMM_WIDTH'(in_instr[15:0]);
                if (in_instr[31:28] == 4'd2) begin
                    dec.causes_stall = (in_instr[19:16] <= BRANCH_MAX_OP);
                end
            end
            4'd5: begin
                dec.rc           = in_instr[19:16];
                dec.opcode       = in_instr[15:12];
                dec.imm          = IMM_WIDTH'($signed(in_instr[11:0]));
                dec.ldst_type    = in_instr[13:12];
                dec.causes_stall = 1'b1;
            end
            default: begin
                dec     = '0;
                dec.bad = 1'b1;
            end
        endcase
    end

    assign full      = (count_q == FullCnt);
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = (state_q == StRun) && !empty && !flush;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;
    assign rd_rec    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bad_count_d = bad_count_q;
        if (push) begin
            mem_d[wr_ptr_q] = dec;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            if (dec.bad && bad_count_q != 16'hFFFF) bad_count_d = bad_count_q + 16'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop) count_d = count_q + (AW + 1)'(1);
        if (pop && !push) count_d = count_q - (AW + 1)'(1);
        unique case (state_q)
            StRun: begin
                if (pop && rd_rec.causes_stall && STALL_CYCLES > 0) begin
                    state_d = StHold;
                    cnt_d   = CW'(STALL_CYCLES);
                end
            end
            StHold: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = StRun;
        endcase
        // Flush wins over everything except the bad-instruction count.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = StRun;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StRun;
            cnt_q       <= '0;
            bad_count_q <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bad_count_q <= bad_count_d;
        end
    end

    assign out_group        = rd_rec.group;
    assign out_ra           = rd_rec.ra;
    assign out_rb           = rd_rec.rb;
    assign out_rc           = rd_rec.rc;
    assign out_opcode       = rd_rec.opcode;
    assign out_imm          = rd_rec.imm;
    assign out_ldst_type    = rd_rec.ldst_type;
    assign out_causes_stall = rd_rec.causes_stall;
    assign out_bad          = rd_rec.bad;
    assign bad_count        = bad_count_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: decode vector table, hold timing, back-pressure, flush,
// bad-instruction counting with saturation, and reset during HOLD.
`timescale 1ns/1ps
module tb_instr_decode_stage;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
    logic [31:0] in_instr = 32'hFFFF_FFFF;
    logic [3:0]  out_group, out_ra, out_rb, out_rc, out_opcode;
    logic [15:0] out_imm, bad_count;
    logic [1:0]  out_ldst_type;
    logic        out_causes_stall, out_bad;

    always #5 clk = ~clk;

    instr_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_group(out_group), .out_ra(out_ra), .out_rb(out_rb), .out_rc(out_rc),
        .out_opcode(out_opcode), .out_imm(out_imm), .out_ldst_type(out_ldst_type),
        .out_causes_stall(out_causes_stall), .out_bad(out_bad), .bad_count(bad_count)
    );

    typedef struct packed {
        logic [3:0]  grp, ra, rb, rc, op;
        logic [15:0] imm;
        logic [1:0]  ldst;
        logic        stall, bad;
    } rec_t;

    typedef struct packed {
        logic [31:0] instr;
        rec_t        exp;
    } vec_t;

    rec_t exp_q[$];
    rec_t cur_exp;
    rec_t bad_rec, rec_s, rec_a;
    vec_t vecs[14];
    bit   sb_en = 1'b1;
    logic last_ov, last_ir, last_push;
    int   n_checks = 0, n_pass = 0;

    function automatic rec_t mk(input logic [3:0] g, ra, rb, rc, op, input logic [15:0] imm,
                                input logic [1:0] ld, input logic st, bd);
        rec_t r;
        r.grp = g; r.ra = ra; r.rb = rb; r.rc = rc; r.op = op;
        r.imm = imm; r.ldst = ld; r.stall = st; r.bad = bd;
        return r;
    endfunction

    function automatic rec_t dut_rec();
        return mk(out_group, out_ra, out_rb, out_rc, out_opcode, out_imm, out_ldst_type,
                  out_causes_stall, out_bad);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input rec_t e);
        in_valid = v;
        in_instr = instr;
        cur_exp  = e;
    endtask

    // One clock: sample #1 after the falling edge, score pops/pushes, advance to next falling edge.
    task automatic cycle();
        rec_t e;
        #1;
        last_ov   = out_valid;
        last_ir   = in_ready;
        last_push = in_valid && in_ready && !flush;
        if (sb_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL pop_unexpected: got record %0h, required no record", dut_rec());
            end else begin
                e = exp_q.pop_front();
                check("pop_record", 64'(dut_rec()), 64'(e));
            end
        end
        if (flush) exp_q.delete();
        else if (sb_en && last_push) exp_q.push_back(cur_exp);
        @(negedge clk);
    endtask

    task automatic push_one(input logic [31:0] instr, input rec_t e);
        drive(1'b1, instr, e);
        last_push = 1'b0;
        for (int k = 0; k < 20 && !last_push; k++) cycle();
        check("accept_timeout", 64'(last_push), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        in_valid = 1'b0;
        for (int k = 0; k < budget && exp_q.size() != 0; k++) cycle();
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset(input string tag);
        in_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        #1;
        check({tag, "_rst_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_rst_in_ready"}, 64'(in_ready), 64'(1));
        check({tag, "_rst_fields"}, 64'(dut_rec()), 64'(0));
        check({tag, "_rst_bad_count"}, 64'(bad_count), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bad_rec   = mk(0, 0, 0, 0, 0, 16'h0, 0, 0, 1);
        rec_s     = mk(5, 1, 2, 3, 2, 16'hFFFF, 2, 1, 0);
        rec_a     = mk(0, 1, 2, 3, 4, 16'h0, 0, 0, 0);
        vecs[0]   = '{32'h0123_0004, rec_a};
        vecs[1]   = '{32'h5123_2FFF, rec_s};
        vecs[2]   = '{32'h1450_8001, mk(1, 4, 5, 0, 0, 16'h8001, 0, 0, 0)};
        vecs[3]   = '{32'h2ABC_D123, mk(2, 4'hA, 4'hB, 0, 4'hC, 16'hD123, 0, 0, 0)};
        vecs[4]   = '{32'h2AB9_0042, mk(2, 4'hA, 4'hB, 0, 9, 16'h0042, 0, 1, 0)};
        vecs[5]   = '{32'h3456_000A, mk(3, 4, 5, 6, 4'hA, 16'h0, 0, 0, 0)};
        vecs[6]   = '{32'h4789_1239, mk(4, 7, 8, 9, 9, 16'h0, 0, 1, 0)};
        vecs[7]   = '{32'h5ABC_9800, mk(5, 4'hA, 4'hB, 4'hC, 9, 16'hF800, 1, 1, 0)};
        vecs[8]   = '{32'h5000_37FF, mk(5, 0, 0, 0, 3, 16'h07FF, 3, 1, 0)};
        vecs[9]   = '{32'hA000_0000, bad_rec};
        vecs[10]  = '{32'hFFFF_FFFF, bad_rec};
        vecs[11]  = '{32'h3000_0000, mk(3, 0, 0, 0, 0, 16'h0, 0, 1, 0)};
        vecs[12]  = '{32'h1FFF_FFFF, mk(1, 4'hF, 4'hF, 0, 4'hF, 16'hFFFF, 0, 0, 0)};
        vecs[13]  = '{32'h4000_000A, mk(4, 0, 0, 0, 4'hA, 16'h0, 0, 0, 0)};

        do_reset("init");

        // Decode table, consumer always ready.
        out_ready = 1'b1;
        foreach (vecs[i]) push_one(vecs[i].instr, vecs[i].exp);
        drain(60);
        check("table_bad_count", 64'(bad_count), 64'(2));

        // Latency and stall hold.
        do_reset("hold");
        out_ready = 1'b1;
        drive(1'b1, 32'h5123_2FFF, rec_s);
        cycle();
        check("hold_empty_ov", 64'(last_ov), 64'(0));
        drive(1'b1, 32'h0123_0004, rec_a);
        cycle();
        check("latency_ov", 64'(last_ov), 64'(1));
        in_valid = 1'b0;
        cycle();
        check("hold_cycle1_ov", 64'(last_ov), 64'(0));
        cycle();
        check("hold_cycle2_ov", 64'(last_ov), 64'(0));
        cycle();
        check("hold_release_ov", 64'(last_ov), 64'(1));
        drain(10);

        // Back-pressure: five pushes into four entries.
        do_reset("full");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, {4'h0, 4'(i + 1), 20'h0, 4'(i + 1)},
                  mk(0, 4'(i + 1), 0, 0, 4'(i + 1), 16'h0, 0, 0, 0));
            cycle();
            check("fill_in_ready", 64'(last_ir), 64'(i < 4));
        end
        check("stall_stable_ov", 64'(out_valid), 64'(1));
        check("stall_stable_rec", 64'(dut_rec()), 64'(mk(0, 1, 0, 0, 1, 16'h0, 0, 0, 0)));
        out_ready = 1'b1;
        cycle();
        check("no_push_through", 64'(last_ir), 64'(0));
        cycle();
        check("fifth_accepted", 64'(last_push), 64'(1));
        drain(20);

        // Bad instruction counting and saturation.
        do_reset("bad");
        out_ready = 1'b1;
        repeat (3) push_one(32'hA000_0000, bad_rec);
        drain(10);
        check("bad_count_3", 64'(bad_count), 64'(3));
        sb_en = 1'b0;
        drive(1'b1, 32'hA000_0000, bad_rec);
        repeat (65532) cycle();
        in_valid = 1'b0;
        cycle();
        check("bad_count_max", 64'(bad_count), 64'(16'hFFFF));
        in_valid = 1'b1;
        repeat (2) cycle();
        in_valid = 1'b0;
        cycle();
        check("bad_count_saturate", 64'(bad_count), 64'(16'hFFFF));
        sb_en = 1'b1;

        // Flush during HOLD with three queued records and a push offered.
        do_reset("flush");
        out_ready = 1'b0;
        push_one(32'h5123_2FFF, rec_s);
        push_one(32'h0123_0004, rec_a);
        push_one(32'h0AB0_0001, mk(0, 4'hA, 4'hB, 0, 1, 16'h0, 0, 0, 0));
        push_one(32'h0CD0_0002, mk(0, 4'hC, 4'hD, 0, 2, 16'h0, 0, 0, 0));
        out_ready = 1'b1;
        cycle();
        check("flush_pre_pop", 64'(last_ov), 64'(1));
        flush = 1'b1;
        drive(1'b1, 32'hA000_0000, bad_rec);
        cycle();
        check("flush_cycle_ov", 64'(last_ov), 64'(0));
        flush    = 1'b0;
        in_valid = 1'b0;
        cycle();
        check("flush_after_ov", 64'(last_ov), 64'(0));
        check("flush_after_in_ready", 64'(last_ir), 64'(1));
        check("flush_bad_count", 64'(bad_count), 64'(0));
        push_one(32'h0123_0004, rec_a);
        cycle();
        check("flush_run_ov", 64'(last_ov), 64'(1));
        cycle();
        check("flush_empty_ov", 64'(last_ov), 64'(0));
        check("flush_sb_empty", 64'(exp_q.size()), 64'(0));

        // Reset while in HOLD with a record queued.
        out_ready = 1'b1;
        push_one(32'h5123_2FFF, rec_s);
        drive(1'b1, 32'h0123_0004, rec_a);
        cycle();
        in_valid = 1'b0;
        do_reset("midhold");
        cycle();
        check("midhold_empty_ov", 64'(last_ov), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, flow-controlled instruction decode stage. It decodes 32-bit instructions in six groups, the same format the core's combinational decoder handles, and queues the decoded records in a parametrised FIFO with valid/ready handshakes on both sides. It enforces a programmable hold after any stall-causing instruction, supports pipeline flush, and counts invalid instructions. It sits between instruction fetch and register read.

## Interface
- `IMM_WIDTH`, 16: output immediate width; must be ≥16.
- `DEPTH`, 4: FIFO entries; a power of 2, ≥2.
- `STALL_CYCLES`, 2: cycles `out_valid` is held low after a stall-causing record transfers; 0 disables the hold.
- `BRANCH_MAX_OP`, 4'd9: group-2 opcodes ≤ this value cause a stall.
- `JUMP_MAX_OP`, 4'd9: same rule for group 3.
- `CALL_MAX_OP`, 4'd9: same rule for group 4.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch offers `in_instr`.
- `in_ready`  out  1  stage accepts an instruction; equals !full.
- `in_instr`  in  32  raw instruction.
- `flush`  in  1  synchronous discard of all queued records.
- `out_valid`  out  1  decoded record available.
- `out_ready`  in  1  consumer accepts the record.
- `out_group`, `out_ra`, `out_rb`, `out_rc`, `out_opcode`  out  4 each  decoded fields.
- `out_imm`  out  IMM_WIDTH  extended immediate.
- `out_ldst_type`  out  2  load/store type.
- `out_causes_stall`  out  1  record requires a stall.
- `out_bad`  out  1  group was invalid.
- `bad_count`  out  16  saturating count of invalid instructions accepted.

## Operation
Decode runs combinationally on `in_instr` and is written into the FIFO on push (`in_valid && in_ready && !flush`). Field positions:
- All groups: group [31:28], ra [27:24], rb [23:20].
- Groups 0, 3, 4:
  - rc [19:16], opcode [3:0], imm 0.
  - Group 0: causes_stall 0.
  - Groups 3 and 4: causes_stall = opcode ≤ `JUMP_MAX_OP` / `CALL_MAX_OP` respectively.
- Groups 1, 2:
  - opcode [19:16], imm [15:0] zero-extended to `IMM_WIDTH`, rc 0.
  - Group 1: causes_stall 0.
  - Group 2: causes_stall = opcode ≤ `BRANCH_MAX_OP`.
- Group 5:
  - rc [19:16], opcode [15:12], imm [11:0] sign-extended to `IMM_WIDTH`.
  - ldst_type = opcode[1:0], causes_stall 1.
- ldst_type is 0 for all groups except 5.
- Groups 6–15: every field 0, `out_bad`=1.
  - `bad_count` increments on push of such a record and saturates at 16'hFFFF.

FIFO and pop:
- FIFO uses read/write pointers with wrap at `DEPTH` and a count of 0..`DEPTH`.
- Pop condition: `out_valid && out_ready`.

Hold FSM:
- RUN: `out_valid` = !empty && !flush.
  - A pop of a record with causes_stall=1 and `STALL_CYCLES`>0 loads the counter with `STALL_CYCLES` and moves to HOLD.
- HOLD: `out_valid`=0. The counter decrements each cycle; at 1 the FSM returns to RUN.
  - Pushes continue during HOLD.
- A flush cycle empties the FIFO and forces RUN with counter 0.
  - A push offered in the flush cycle is dropped.
  - No pop occurs in the flush cycle.
  - `bad_count` is not changed by flush.

Boundary conditions:
- Full: `in_ready`=0. There is no same-cycle push-through when full.
- Simultaneous push and pop when not full: count unchanged.
- Empty: `out_valid`=0. Output fields are don't-care, but must be stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset (asynchronous assert, synchronous use after deassert):
  - FIFO empty, pointers 0, FSM RUN, counter 0, `bad_count` 0.
  - `out_valid` 0, `in_ready` 1, all output fields 0.
- Latency: an instruction pushed in cycle N is visible with `out_valid`=1 in cycle N+1 if the FIFO was empty and the FSM is in RUN.
- Throughput: 1 record/cycle with no stalling records.
- Stall hold: after a stall-causing pop in cycle N, `out_valid`=0 in cycles N+1..N+`STALL_CYCLES`. The next pop is possible in cycle N+`STALL_CYCLES`+1.
- Reset mid-HOLD or with the FIFO partly full returns immediately to the reset state.

## Test plan
- Push 32'h0123_0004 with `out_ready`=1 → next cycle group 0, ra 1, rb 2, rc 3, opcode 4, imm 0, causes_stall 0, bad 0.
- Push 32'h5123_2FFF, `IMM_WIDTH`=16, `STALL_CYCLES`=2 → opcode 2, imm 16'hFFFF, ldst_type 2, causes_stall 1. After its pop, `out_valid`=0 for exactly 2 cycles even with a queued group-0 record, which then pops in cycle 3.
- Push 32'h1450_8001 → group 1, ra 4, rb 5, opcode 0, imm 16'h8001 (zero-extended), rc 0.
- `DEPTH`=4, `out_ready`=0, push 5 back-to-back → `in_ready` low after the 4th push. The 5th instruction is accepted only after one pop, and order is preserved.
- Push 32'hA000_0000 three times → `out_bad`=1, all fields 0, `bad_count`=3. Preload `bad_count` at 16'hFFFF via a long run → it stays 16'hFFFF.
- Fill 3 entries, enter HOLD, assert `flush` together with `in_valid` → next cycle empty, RUN, `out_valid` 0, pushed instruction absent, `bad_count` unchanged.
